seg_digit_drive: RTL and testbench

Downstream consumer of the 4-bit rotating digit-select shift register in the calculator display path. It takes that register's active-low one-hot pattern, selects the matching nibble of a double-buffered 16-bit display value, and drives the board's anodes, 7-segment cathodes and decimal point. It adds leading-zero blanking, a one-cycle anode dead time on every digit change to suppress ghosting, and a sticky error flag for illegal select patterns.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_digit_drive_if.sv | 14 +
 rtl/hex7seg.sv | 9 +
 rtl/seg_digit_drive.sv | 121 ++++++++++++
 tb/tb_seg_digit_drive.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: off patterns, legal
// digit-select codes and the active-low hex-to-segment table.
package seg_pkg;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] SEL_D0 = 4'b1110;
  localparam logic [3:0] SEL_D1 = 4'b1101;
  localparam logic [3:0] SEL_D2 = 4'b1011;
  localparam logic [3:0] SEL_D3 = 4'b0111;

  // Segment order {g,f,e,d,c,b,a}, active-low; leftmost entry is nibble F.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
  } disp_buf_t;

endpackage

// File: rtl/seg_digit_drive_if.sv
// Display-value load port, digit-select input and board-facing drive outputs.
interface seg_digit_drive_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        err;

  modport master (output load, value, dp, sel, input an, seg, dp_n, err);
  modport slave  (input load, value, dp, sel, output an, seg, dp_n, err);
endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/seg_digit_drive.sv
// Digit driver: double-buffered display value, leading-zero blanking,
// one-cycle anode dead time on every select change, sticky illegal-select flag.
module seg_digit_drive
  import seg_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  seg_digit_drive_if.slave  bus
);

  logic [3:0] sel_q, sel_d;
  disp_buf_t  active_q, active_d;
  disp_buf_t  pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_n_q, dp_n_d;
  logic       err_q, err_d;

  logic       sel_legal;
  logic [1:0] digit_idx;
  logic [3:0] digit_zero;
  logic [3:0] lz_chain;
  logic [3:0] nibble;
  logic [6:0] nibble_seg;
  logic       blank;
  logic       boundary;

  always_comb begin
    sel_legal = 1'b1;
    digit_idx = 2'd0;
    case (bus.sel)
      SEL_D0:  digit_idx = 2'd0;
      SEL_D1:  digit_idx = 2'd1;
      SEL_D2:  digit_idx = 2'd2;
      SEL_D3:  digit_idx = 2'd3;
      default: sel_legal = 1'b0;
    endcase
  end

  // lz_chain[k]: digits 3..k hold a zero nibble and no decimal point.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lz
      assign digit_zero[gi] = (active_q.value[4*gi +: 4] == 4'h0) && !active_q.dp[gi];
      assign lz_chain[gi]   = &digit_zero[3:gi];
    end
  endgenerate

  assign nibble   = active_q.value[{digit_idx, 2'b00} +: 4];
  assign blank    = BLANK_LZ && (digit_idx != 2'd0) && lz_chain[digit_idx];
  assign boundary = (bus.sel == SEL_D0) && (sel_q != SEL_D0);

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (nibble_seg)
  );

  always_comb begin
    sel_d        = bus.sel;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    dp_n_d       = 1'b1;
    err_d        = err_q;

    // A load landing on the frame boundary bypasses the pending buffer.
    if (bus.load && boundary) begin
      active_d     = '{value: bus.value, dp: bus.dp};
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_d       = '{value: bus.value, dp: bus.dp};
      pend_valid_d = 1'b1;
    end else if (boundary && pend_valid_q) begin
      active_d     = pend_q;
      pend_valid_d = 1'b0;
    end

    if (!sel_legal) begin
      err_d = 1'b1;
    end else if (bus.sel == sel_q) begin
      an_d = bus.sel;
      if (!blank) begin
        seg_d  = nibble_seg;
        dp_n_d = !active_q.dp[digit_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q        <= SEL_D0;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      err_q        <= err_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp_n = dp_n_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_seg_digit_drive.sv
// Directed bench for seg_digit_drive with a per-cycle behavioural model.
module tb_seg_digit_drive;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_digit_drive_if bus_if ();

  seg_digit_drive #(.BLANK_LZ(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp_n;
  logic       exp_err;
  bit         model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] sg, input logic dpn);
    chk({name, ".an"}, {28'd0, bus_if.an}, {28'd0, an});
    chk({name, ".seg"}, {25'd0, bus_if.seg}, {25'd0, sg});
    chk({name, ".dp_n"}, {31'd0, bus_if.dp_n}, {31'd0, dpn});
  endtask

  // Model: outputs after an edge follow from the select seen at that edge,
  // the select one edge earlier, and the value committed before that edge.
  initial begin : model
    logic [6:0]  seg_rom [16];
    logic [3:0]  m_sel_q;
    logic [15:0] m_val, p_val, upper;
    logic [3:0]  m_dp, p_dp, nib;
    bit          p_valid, m_err, bnd;
    int          d;
    seg_rom = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_sel_q = 4'b1110; m_val = '0; m_dp = '0; p_val = '0; p_dp = '0;
    p_valid = 1'b0; m_err = 1'b0;
    forever begin
      @(posedge clk);
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp_n = 1'b1;
      if (reset) begin
        m_sel_q = 4'b1110; m_val = '0; m_dp = '0; p_val = '0; p_dp = '0;
        p_valid = 1'b0; m_err = 1'b0;
      end else begin
        if ($countones(~bus_if.sel) != 1) begin
          m_err = 1'b1;
        end else if (bus_if.sel == m_sel_q) begin
          d = 0;
          for (int k = 0; k < 4; k++) if (!bus_if.sel[k]) d = k;
          upper  = m_val >> (4 * d);
          nib    = upper[3:0];
          exp_an = bus_if.sel;
          if (!(d > 0 && upper == 16'd0 && (m_dp >> d) == 4'd0)) begin
            exp_seg  = seg_rom[nib];
            exp_dp_n = !m_dp[d];
          end
        end
        bnd = (bus_if.sel == 4'b1110) && (m_sel_q != 4'b1110);
        if (bus_if.load && bnd) begin
          m_val = bus_if.value; m_dp = bus_if.dp; p_valid = 1'b0;
        end else if (bus_if.load) begin
          p_val = bus_if.value; p_dp = bus_if.dp; p_valid = 1'b1;
        end else if (bnd && p_valid) begin
          m_val = p_val; m_dp = p_dp; p_valid = 1'b0;
        end
        m_sel_q = bus_if.sel;
      end
      exp_err = m_err;
      model_valid = 1'b1;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("model.an", {28'd0, bus_if.an}, {28'd0, exp_an});
        chk("model.seg", {25'd0, bus_if.seg}, {25'd0, exp_seg});
        chk("model.dp_n", {31'd0, bus_if.dp_n}, {31'd0, exp_dp_n});
        chk("model.err", {31'd0, bus_if.err}, {31'd0, exp_err});
      end
    end
  end

  task automatic cyc(input logic [3:0] s, input logic ld, input logic [15:0] v, input logic [3:0] d);
    bus_if.sel   = s;
    bus_if.load  = ld;
    bus_if.value = v;
    bus_if.dp    = d;
    @(negedge clk);
    bus_if.load = 1'b0;
  endtask

  // Move to a digit for a 4-cycle dwell: one dead cycle, then the digit.
  task automatic show(input string name, input logic [3:0] s, input logic [6:0] sg, input logic dpn,
                      input logic ld, input logic [15:0] v, input logic [3:0] d);
    cyc(s, ld, v, d);
    lit({name, "_dead"}, 4'hF, 7'h7F, 1'b1);
    cyc(s, 1'b0, v, d);
    lit(name, s, sg, dpn);
    repeat (2) cyc(s, 1'b0, v, d);
    $display("step %s sel=%b load=%0b an=%b seg=%b dp_n=%b err=%b",
             name, s, ld, bus_if.an, bus_if.seg, bus_if.dp_n, bus_if.err);
  endtask

  initial begin : stim
    reset = 1'b1;
    bus_if.sel = 4'b1110; bus_if.load = 1'b0; bus_if.value = '0; bus_if.dp = '0;
    repeat (2) @(negedge clk);
    lit("reset", 4'hF, 7'h7F, 1'b1);
    chk("reset.err", {31'd0, bus_if.err}, 32'd0);
    $display("step reset an=%b seg=%b err=%b", bus_if.an, bus_if.seg, bus_if.err);
    reset = 1'b0;
    repeat (2) cyc(4'b1110, 1'b0, 16'h0, 4'h0);
    lit("idle_d0", 4'b1110, 7'b1000000, 1'b1);

    // Load 0x12AF while digit 0 is on; it commits at the next wrap.
    cyc(4'b1110, 1'b1, 16'h12AF, 4'h0);
    show("old_d1", 4'b1101, 7'h7F, 1'b1, 1'b0, 16'h0, 4'h0);
    show("old_d2", 4'b1011, 7'h7F, 1'b1, 1'b0, 16'h0, 4'h0);
    show("old_d3", 4'b0111, 7'h7F, 1'b1, 1'b0, 16'h0, 4'h0);
    show("hex_d0", 4'b1110, 7'b0001110, 1'b1, 1'b0, 16'h0, 4'h0);
    show("hex_d1", 4'b1101, 7'b0001000, 1'b1, 1'b0, 16'h0, 4'h0);
    show("hex_d2", 4'b1011, 7'b0100100, 1'b1, 1'b0, 16'h0, 4'h0);
    show("hex_d3", 4'b0111, 7'b1111001, 1'b1, 1'b0, 16'h0, 4'h0);

    // Leading-zero blanking, then the same value with dp on digit 2.
    cyc(4'b0111, 1'b1, 16'h0007, 4'h0);
    show("lz_d0", 4'b1110, 7'b1111000, 1'b1, 1'b0, 16'h0, 4'h0);
    show("lz_d1", 4'b1101, 7'h7F, 1'b1, 1'b1, 16'h0007, 4'b0100);
    show("lz_d2", 4'b1011, 7'h7F, 1'b1, 1'b0, 16'h0, 4'h0);
    show("lz_d3", 4'b0111, 7'h7F, 1'b1, 1'b0, 16'h0, 4'h0);
    show("dp_d0", 4'b1110, 7'b1111000, 1'b1, 1'b0, 16'h0, 4'h0);
    show("dp_d1", 4'b1101, 7'b1000000, 1'b1, 1'b0, 16'h0, 4'h0);
    show("dp_d2", 4'b1011, 7'b1000000, 1'b0, 1'b0, 16'h0, 4'h0);
    show("dp_d3", 4'b0111, 7'h7F, 1'b1, 1'b0, 16'h0, 4'h0);

    // Mid-frame loads are held back until the wrap; the second one wins.
    show("mid_d0", 4'b1110, 7'b1111000, 1'b1, 1'b0, 16'h0, 4'h0);
    show("mid_d1", 4'b1101, 7'b1000000, 1'b1, 1'b0, 16'h0, 4'h0);
    show("mid_d2", 4'b1011, 7'b1000000, 1'b0, 1'b1, 16'h1111, 4'h0);
    show("mid_d3", 4'b0111, 7'h7F, 1'b1, 1'b1, 16'h2222, 4'h0);
    show("two_d0", 4'b1110, 7'b0100100, 1'b1, 1'b0, 16'h0, 4'h0);
    show("two_d1", 4'b1101, 7'b0100100, 1'b1, 1'b0, 16'h0, 4'h0);
    show("two_d2", 4'b1011, 7'b0100100, 1'b1, 1'b0, 16'h0, 4'h0);
    show("two_d3", 4'b0111, 7'b0100100, 1'b1, 1'b0, 16'h0, 4'h0);

    // Load on the boundary edge shows in the same frame and leaves nothing pending.
    show("coin_d0", 4'b1110, 7'b0000010, 1'b1, 1'b1, 16'h3456, 4'h0);
    show("coin_d1", 4'b1101, 7'b0010010, 1'b1, 1'b0, 16'h0, 4'h0);
    show("coin_d2", 4'b1011, 7'b0011001, 1'b1, 1'b0, 16'h0, 4'h0);
    show("coin_d3", 4'b0111, 7'b0110000, 1'b1, 1'b0, 16'h0, 4'h0);
    show("keep_d0", 4'b1110, 7'b0000010, 1'b1, 1'b0, 16'h0, 4'h0);

    // Rotating every cycle keeps the anodes off without flagging an error.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] s;
      s = 4'b1111 ^ (4'b0001 << ((i + 1) % 4));
      cyc(s, 1'b0, 16'h0, 4'h0);
    end
    lit("fast", 4'hF, 7'h7F, 1'b1);
    chk("fast.err", {31'd0, bus_if.err}, 32'd0);
    $display("step fast an=%b err=%b", bus_if.an, bus_if.err);

    // Illegal select sets a sticky error.
    cyc(4'b1100, 1'b0, 16'h0, 4'h0);
    lit("illegal", 4'hF, 7'h7F, 1'b1);
    chk("illegal.err", {31'd0, bus_if.err}, 32'd1);
    $display("step illegal an=%b err=%b", bus_if.an, bus_if.err);
    show("err_d0", 4'b1110, 7'b0000010, 1'b1, 1'b0, 16'h0, 4'h0);
    chk("sticky.err0", {31'd0, bus_if.err}, 32'd1);
    show("err_d1", 4'b1101, 7'b0010010, 1'b1, 1'b0, 16'h0, 4'h0);
    chk("sticky.err1", {31'd0, bus_if.err}, 32'd1);

    // Reset mid-frame overrides a simultaneous load.
    reset = 1'b1;
    cyc(4'b1011, 1'b1, 16'hFFFF, 4'hF);
    lit("midreset", 4'hF, 7'h7F, 1'b1);
    chk("midreset.err", {31'd0, bus_if.err}, 32'd0);
    $display("step midreset an=%b err=%b", bus_if.an, bus_if.err);
    reset = 1'b0;
    cyc(4'b1011, 1'b0, 16'h0, 4'h0);
    lit("post_dead", 4'hF, 7'h7F, 1'b1);
    cyc(4'b1011, 1'b0, 16'h0, 4'h0);
    lit("post_d2", 4'b1011, 7'h7F, 1'b1);
    show("post_d3", 4'b0111, 7'h7F, 1'b1, 1'b0, 16'h0, 4'h0);
    show("post_d0", 4'b1110, 7'b1000000, 1'b1, 1'b0, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
